sprite_blitter: RTL and testbench
=================================

Name: sprite_blitter

Overview:
- Parametrised pixel-drawing engine feeding the vga_adapter x/y/colour/plot write port.
- Accepts one draw command at a time over a valid/ready handshake; the command is either a solid rectangle fill or a sprite copy from a synchronous sprite ROM.
- Sprite copies support transparency keying. Every pixel is clipped to the screen bounds.
- Replaces hard-coded per-item draw states. A top-level sequencer issues commands instead.

Parameters:
- SCREEN_W, 320, screen width in pixels.
- SCREEN_H, 240, screen height in pixels.
- X_W, 9, x coordinate width.
- Y_W, 8, y coordinate width.
- SPR_W, 16, sprite width in pixels (power of two).
- SPR_H, 16, sprite height in pixels (power of two).
- NUM_SPRITES, 4, number of sprites stored in the ROM.
- COLOUR_W, 12, colour width (4 bits per channel).
- ROM_AW, 10, ROM address width, equal to clog2(NUM_SPRITES*SPR_W*SPR_H).
- TRANSPARENT, 12'hF0F, colour key that is skipped when cmd_key=1.

Ports:
- CLOCK_50  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  a command is present on the cmd_* inputs.
- cmd_ready  out  1  the block can accept a command (IDLE only).
- cmd_mode  in  1  0 = fill, 1 = sprite.
- cmd_x  in  X_W  top-left x.
- cmd_y  in  Y_W  top-left y.
- cmd_w  in  X_W  fill width (ignored in sprite mode).
- cmd_h  in  Y_W  fill height (ignored in sprite mode).
- cmd_colour  in  COLOUR_W  fill colour.
- cmd_id  in  clog2(NUM_SPRITES)  sprite index.
- cmd_key  in  1  enables transparency in sprite mode.
- rom_addr  out  ROM_AW  sprite ROM address.
- rom_data  in  COLOUR_W  ROM read data, valid one cycle after the address.
- x  out  X_W  pixel x to the adapter.
- y  out  Y_W  pixel y to the adapter.
- colour  out  COLOUR_W  pixel colour to the adapter.
- plot  out  1  write strobe for the adapter.
- busy  out  1  a command is in progress.
- done  out  1  one-cycle pulse when a command completes.

Behaviour:
- Reset values: while reset is high, every output is 0 (cmd_ready, plot, x, y, colour, busy, done, rom_addr) and the state is IDLE.
- Reset mid-command aborts the command immediately. No further plot is issued.
- cmd_ready is 1 on the first clock after reset deasserts.
- States and transitions:
  - IDLE: cmd_ready=1. A command is accepted on the cycle cmd_valid&&cmd_ready, which latches all cmd_* fields. Then go to FILL (mode 0) or SPRITE (mode 1).
  - FILL: scan col 0..cmd_w-1 innermost, then row 0..cmd_h-1. One pixel per cycle: x=cmd_x+col, y=cmd_y+row, colour=cmd_colour.
    - Accept at cycle N → first pixel at N+1, last pixel at N+w*h, done at N+w*h+1 (state DONE).
    - If cmd_w==0 or cmd_h==0, go straight to DONE with no plot (done at N+1).
  - SPRITE: rom_addr = cmd_id*SPR_W*SPR_H + row*SPR_W + col, issued in raster order at one address per cycle. The data is used one cycle later via a one-stage pipeline that holds x, y and a valid bit.
    - Accept at N → first address at N+1, first pixel at N+2, last address at N+SPR_W*SPR_H.
    - After the last address, go to FLUSH for one cycle (last pixel at N+1+SPR_W*SPR_H), then DONE (done pulse at N+2+SPR_W*SPR_H).
  - DONE: done=1 for one cycle, busy=0, then IDLE. cmd_ready rises the cycle after done.
- Plot gating: plot=1 only for a valid pipeline pixel that passes both checks below. Suppressed pixels still take their cycle, so latency is fixed regardless of image content.
  - Clipping: the pixel is dropped when x>=SCREEN_W or y>=SCREEN_H. Coordinate sums use X_W+1 / Y_W+1 bits so that wrap-around never maps a pixel back on screen.
  - Transparency: the pixel is dropped when mode=sprite, key=1 and rom_data==TRANSPARENT.
- Outputs x, y, colour and plot are registered. colour/x/y hold their last value when plot=0.
- busy=1 from the cycle after acceptance through FLUSH.
- cmd_valid while not ready is ignored; the producer must hold the command until it is accepted.
- An out-of-range cmd_id (>= NUM_SPRITES) is treated as cmd_id modulo NUM_SPRITES.

Decomposition:
- Shared package vga_pkg holds:
  - screen constants SCREEN_W, SCREEN_H, X_W, Y_W, COLOUR_W;
  - mode encodings MODE_FILL=0, MODE_SPRITE=1;
  - the blitter state encoding (IDLE, FILL, SPRITE, FLUSH, DONE).
- One sub-module, blit_scan_counter: a col/row raster counter with programmable width and height, providing last-pixel and last-row flags. FILL and SPRITE both reuse it.

Test Plan:
- Fill: x=10, y=20, w=3, h=2, colour=12'h0F0 → plots in order (10,20), (11,20), (12,20), (10,21), (11,21), (12,21) on cycles N+1..N+6, all with colour 0F0; done at N+7.
- Sprite: id=1, x=16, y=16, key=0, ROM holding the address as data → 256 plots over cycles N+2..N+257; the pixel at (16+c, 16+r) has colour 256+16r+c; done at N+258.
- Transparency: id=0, key=1, ROM word 5 = 12'hF0F → exactly 255 plots and no plot at (x+5, y). With key=0, 256 plots.
- Clipping: fill x=318, y=238, w=4, h=4 → plots only (318,238), (319,238), (318,239), (319,239); done still at N+17.
- Zero size and back-pressure: fill w=0 → done at N+1 with no plot. Raise cmd_valid during busy → cmd_ready stays 0 and the command is accepted only the cycle after done.
- Reset mid-sprite: assert reset at N+50 → plot, busy and done go to 0 asynchronously in the same cycle. After release, cmd_ready=1 and a new fill runs correctly.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA constants, command mode encodings and the blitter state encoding.
package vga_pkg;

   localparam int SCREEN_W = 320;
   localparam int SCREEN_H = 240;
   localparam int X_W      = 9;
   localparam int Y_W      = 8;
   localparam int COLOUR_W = 12;

   localparam logic MODE_FILL   = 1'b0;
   localparam logic MODE_SPRITE = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILL,
      ST_SPRITE,
      ST_FLUSH,
      ST_DONE
   } blit_state_e;

endpackage

// File: rtl/blit_scan_counter.sv
// Raster col/row counter: col is innermost, wraps to (0,0) after the last pixel.
module blit_scan_counter #(
   parameter int CW = 9,
   parameter int RW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          adv,
   input  logic [CW-1:0] width,
   input  logic [RW-1:0] height,
   output logic [CW-1:0] col,
   output logic [RW-1:0] row,
   output logic          last_pix
);

   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic          last_col, last_row;

   // width/height of zero are never scanned; the caller skips them
   assign last_col = (col_q == width - CW'(1));
   assign last_row = (row_q == height - RW'(1));
   assign last_pix = last_col && last_row;
   assign col      = col_q;
   assign row      = row_q;

   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (start) begin
         col_d = '0;
         row_d = '0;
      end else if (adv) begin
         if (last_col) begin
            col_d = '0;
            row_d = last_row ? '0 : row_q + RW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_q <= '0;
         row_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

endmodule

// File: rtl/sprite_blitter.sv
// Pixel engine for the VGA adapter write port: solid rectangle fill or keyed sprite
// copy from a synchronous ROM, one pixel per cycle, clipped to the screen.
module sprite_blitter
   import vga_pkg::*;
#(
   parameter int SCREEN_W    = vga_pkg::SCREEN_W,
   parameter int SCREEN_H    = vga_pkg::SCREEN_H,
   parameter int X_W         = vga_pkg::X_W,
   parameter int Y_W         = vga_pkg::Y_W,
   parameter int SPR_W       = 16,
   parameter int SPR_H       = 16,
   parameter int NUM_SPRITES = 4,
   parameter int COLOUR_W    = vga_pkg::COLOUR_W,
   parameter int ROM_AW      = 10,
   parameter logic [COLOUR_W-1:0] TRANSPARENT = 12'hF0F,
   parameter int ID_W        = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
   input  logic                CLOCK_50,
   input  logic                reset,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_mode,
   input  logic [X_W-1:0]      cmd_x,
   input  logic [Y_W-1:0]      cmd_y,
   input  logic [X_W-1:0]      cmd_w,
   input  logic [Y_W-1:0]      cmd_h,
   input  logic [COLOUR_W-1:0] cmd_colour,
   input  logic [ID_W-1:0]     cmd_id,
   input  logic                cmd_key,
   output logic [ROM_AW-1:0]   rom_addr,
   input  logic [COLOUR_W-1:0] rom_data,
   output logic [X_W-1:0]      x,
   output logic [Y_W-1:0]      y,
   output logic [COLOUR_W-1:0] colour,
   output logic                plot,
   output logic                busy,
   output logic                done
);

   typedef struct packed {
      logic                mode;
      logic [X_W-1:0]      x;
      logic [Y_W-1:0]      y;
      logic [X_W-1:0]      w;
      logic [Y_W-1:0]      h;
      logic [COLOUR_W-1:0] colour;
      logic [ID_W-1:0]     id;
      logic                key;
   } blit_cmd_t;

   localparam logic [X_W:0] SCR_W_L = (X_W+1)'(SCREEN_W);
   localparam logic [Y_W:0] SCR_H_L = (Y_W+1)'(SCREEN_H);
   localparam int           SPR_PIX = SPR_W * SPR_H;

   blit_state_e         state_q, state_d;
   blit_cmd_t           cmd_q, cmd_d;
   logic                live_q, live_d;
   logic                pv_q, pv_d;
   logic [X_W:0]        px_q, px_d;
   logic [Y_W:0]        py_q, py_d;
   logic                plot_q, plot_d;
   logic [X_W-1:0]      x_q, x_d;
   logic [Y_W-1:0]      y_q, y_d;
   logic [COLOUR_W-1:0] colour_q, colour_d;

   logic                scan_start, scan_adv, scan_last;
   logic [X_W-1:0]      scan_col, scan_w;
   logic [Y_W-1:0]      scan_row, scan_h;
   logic [X_W:0]        pix_x;
   logic [Y_W:0]        pix_y;
   logic [ROM_AW-1:0]   spr_addr;
   logic                fill_on, pipe_on, keyed;

   assign scan_w = (cmd_q.mode == MODE_SPRITE) ? X_W'(SPR_W) : cmd_q.w;
   assign scan_h = (cmd_q.mode == MODE_SPRITE) ? Y_W'(SPR_H) : cmd_q.h;

   blit_scan_counter #(.CW(X_W), .RW(Y_W)) u_scan (
      .clk      (CLOCK_50),
      .rst      (reset),
      .start    (scan_start),
      .adv      (scan_adv),
      .width    (scan_w),
      .height   (scan_h),
      .col      (scan_col),
      .row      (scan_row),
      .last_pix (scan_last)
   );

   // one extra bit so a sum past the top of the coordinate range stays off screen
   assign pix_x    = {1'b0, cmd_q.x} + {1'b0, scan_col};
   assign pix_y    = {1'b0, cmd_q.y} + {1'b0, scan_row};
   assign spr_addr = ROM_AW'(cmd_q.id) * ROM_AW'(SPR_PIX)
                   + ROM_AW'(scan_row) * ROM_AW'(SPR_W) + ROM_AW'(scan_col);
   assign fill_on  = (pix_x < SCR_W_L) && (pix_y < SCR_H_L);
   assign pipe_on  = (px_q < SCR_W_L) && (py_q < SCR_H_L);
   assign keyed    = cmd_q.key && (rom_data == TRANSPARENT);

   assign rom_addr = (state_q == ST_SPRITE) ? spr_addr : '0;
   assign busy     = (state_q == ST_FILL) || (state_q == ST_SPRITE) || (state_q == ST_FLUSH);
   assign done     = (state_q == ST_DONE);
   assign plot     = plot_q;
   assign x        = x_q;
   assign y        = y_q;
   assign colour   = colour_q;

   always_comb begin
      state_d    = state_q;
      cmd_d      = cmd_q;
      live_d     = 1'b1;
      scan_start = 1'b0;
      scan_adv   = 1'b0;
      cmd_ready  = (state_q == ST_IDLE) && live_q;
      unique case (state_q)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               cmd_d.mode   = cmd_mode;
               cmd_d.x      = cmd_x;
               cmd_d.y      = cmd_y;
               cmd_d.w      = cmd_w;
               cmd_d.h      = cmd_h;
               cmd_d.colour = cmd_colour;
               cmd_d.id     = ID_W'(32'(cmd_id) % NUM_SPRITES);
               cmd_d.key    = cmd_key;
               scan_start   = 1'b1;
               if (cmd_mode == MODE_SPRITE)
                  state_d = ST_SPRITE;
               else if ((cmd_w == '0) || (cmd_h == '0))
                  state_d = ST_DONE;
               else
                  state_d = ST_FILL;
            end
         end
         ST_FILL: begin
            scan_adv = 1'b1;
            if (scan_last) state_d = ST_DONE;
         end
         ST_SPRITE: begin
            scan_adv = 1'b1;
            if (scan_last) state_d = ST_FLUSH;
         end
         ST_FLUSH: state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Sprite stage: coordinates travel alongside the ROM read, colour arrives next cycle.
   always_comb begin
      pv_d     = (state_q == ST_SPRITE);
      px_d     = pix_x;
      py_d     = pix_y;
      plot_d   = 1'b0;
      x_d      = x_q;
      y_d      = y_q;
      colour_d = colour_q;
      if (state_q == ST_FILL) begin
         if (fill_on) begin
            plot_d   = 1'b1;
            x_d      = pix_x[X_W-1:0];
            y_d      = pix_y[Y_W-1:0];
            colour_d = cmd_q.colour;
         end
      end else if (pv_q) begin
         if (pipe_on && !keyed) begin
            plot_d   = 1'b1;
            x_d      = px_q[X_W-1:0];
            y_d      = py_q[Y_W-1:0];
            colour_d = rom_data;
         end
      end
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cmd_q    <= '0;
         live_q   <= 1'b0;
         pv_q     <= 1'b0;
         px_q     <= '0;
         py_q     <= '0;
         plot_q   <= 1'b0;
         x_q      <= '0;
         y_q      <= '0;
         colour_q <= '0;
      end else begin
         state_q  <= state_d;
         cmd_q    <= cmd_d;
         live_q   <= live_d;
         pv_q     <= pv_d;
         px_q     <= px_d;
         py_q     <= py_d;
         plot_q   <= plot_d;
         x_q      <= x_d;
         y_q      <= y_d;
         colour_q <= colour_d;
      end
   end

endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter: stimulus pushes expected pixels/done cycles,
// a negedge monitor pops and compares whenever plot or done is seen.
module tb_sprite_blitter;

   logic        CLOCK_50 = 1'b0;
   logic        reset    = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_mode = 1'b0;
   logic [8:0]  cmd_x = '0;
   logic [7:0]  cmd_y = '0;
   logic [8:0]  cmd_w = '0;
   logic [7:0]  cmd_h = '0;
   logic [11:0] cmd_colour = '0;
   logic [1:0]  cmd_id = '0;
   logic        cmd_key = 1'b0;
   logic [9:0]  rom_addr;
   logic [11:0] rom_data = '0;
   logic [8:0]  x;
   logic [7:0]  y;
   logic [11:0] colour;
   logic        plot, busy, done;

   sprite_blitter dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_mode(cmd_mode), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
      .cmd_colour(cmd_colour), .cmd_id(cmd_id), .cmd_key(cmd_key), .rom_addr(rom_addr),
      .rom_data(rom_data), .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   logic [11:0] rom [1024];
   always @(posedge CLOCK_50) rom_data <= rom[rom_addr];

   // cyc holds N at the negedge after accept edge N
   int cyc = 0;
   always @(posedge CLOCK_50) cyc <= cyc + 1;

   typedef struct { int x; int y; int c; int t; } pix_t;
   pix_t exp_q[$];
   int   done_q[$];
   pix_t me;
   int   checks = 0, errors = 0, plot_cnt = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // plot/x/y/colour are registered: they appear after edge t.
   // done is decoded from state: the adapter sees it at the following edge (cyc+1).
   always @(negedge CLOCK_50) begin
      if (!reset) begin
         if (plot) begin
            plot_cnt++;
            if (exp_q.size() == 0) chk("unexpected_plot", 1, 0);
            else begin
               me = exp_q.pop_front();
               chk("pix_x", int'(x), me.x);
               chk("pix_y", int'(y), me.y);
               chk("pix_colour", int'(colour), me.c);
               chk("pix_cycle", cyc, me.t);
            end
         end
         if (done) begin
            if (done_q.size() == 0) chk("unexpected_done", 1, 0);
            else chk("done_cycle", cyc + 1, done_q.pop_front());
         end
      end
   end

   // Returns at the negedge before the accept edge, with n = accept edge index.
   task automatic issue(input logic mode, input int cx, input int cy, input int w, input int h,
                        input int col, input int id, input logic key, output int n);
      @(negedge CLOCK_50);
      cmd_mode = mode; cmd_x = 9'(cx); cmd_y = 8'(cy); cmd_w = 9'(w); cmd_h = 8'(h);
      cmd_colour = 12'(col); cmd_id = 2'(id); cmd_key = key; cmd_valid = 1'b1;
      n = -1;
      for (int i = 0; i < 2000; i++) begin
         if (busy) chk("ready_low_while_busy", int'(cmd_ready), 0);
         if (cmd_ready) begin
            n = cyc + 1;
            break;
         end
         @(negedge CLOCK_50);
      end
      if (n < 0) chk("accept_timeout", 0, 1);
   endtask

   task automatic drop();
      @(negedge CLOCK_50);
      cmd_valid = 1'b0;
   endtask

   task automatic push_fill(input int n, input int cx, input int cy, input int w, input int h, input int col);
      for (int r = 0; r < h; r++)
         for (int c = 0; c < w; c++)
            if (cx + c < 320 && cy + r < 240)
               exp_q.push_back('{cx + c, cy + r, col, n + 1 + r * w + c});
      done_q.push_back((w * h == 0) ? n + 1 : n + w * h + 1);
   endtask

   task automatic push_sprite(input int n, input int cx, input int cy, input int id, input logic key);
      for (int r = 0; r < 16; r++)
         for (int c = 0; c < 16; c++) begin
            int d;
            d = int'(rom[(id % 4) * 256 + r * 16 + c]);
            if (cx + c < 320 && cy + r < 240 && !(key && d == 12'hF0F))
               exp_q.push_back('{cx + c, cy + r, d, n + 2 + r * 16 + c});
         end
      done_q.push_back(n + 258);
   endtask

   task automatic drain(input string name);
      int i;
      for (i = 0; i < 2000; i++) begin
         if (exp_q.size() == 0 && done_q.size() == 0 && cmd_ready) break;
         @(negedge CLOCK_50);
      end
      chk(name, exp_q.size() + done_q.size(), 0);
   endtask

   initial begin
      int n, n2, p0;
      for (int i = 0; i < 1024; i++) rom[i] = 12'(i);

      @(negedge CLOCK_50);
      chk("rst_ready", int'(cmd_ready), 0);
      chk("rst_plot", int'(plot), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_xy", int'(x) + int'(y), 0);
      chk("rst_colour", int'(colour), 0);
      chk("rst_rom_addr", int'(rom_addr), 0);
      reset = 1'b0;
      @(negedge CLOCK_50);
      chk("ready_after_reset", int'(cmd_ready), 1);

      // basic fill
      issue(1'b0, 10, 20, 3, 2, 12'h0F0, 0, 1'b0, n);
      push_fill(n, 10, 20, 3, 2, 12'h0F0);
      drop();
      drain("fill_drain");

      // sprite 1, ROM data equals address
      issue(1'b1, 16, 16, 0, 0, 0, 1, 1'b0, n);
      push_sprite(n, 16, 16, 1, 1'b0);
      drop();
      drain("sprite_drain");

      // transparency keyed and unkeyed
      rom[5] = 12'hF0F;
      p0 = plot_cnt;
      issue(1'b1, 100, 50, 0, 0, 0, 0, 1'b1, n);
      push_sprite(n, 100, 50, 0, 1'b1);
      drop();
      drain("key_drain");
      chk("key_plot_count", plot_cnt - p0, 255);
      p0 = plot_cnt;
      issue(1'b1, 100, 50, 0, 0, 0, 0, 1'b0, n);
      push_sprite(n, 100, 50, 0, 1'b0);
      drop();
      drain("nokey_drain");
      chk("nokey_plot_count", plot_cnt - p0, 256);
      rom[5] = 12'd5;

      // clipping at the bottom-right corner; x/y hold the last plotted pixel
      issue(1'b0, 318, 238, 4, 4, 12'h123, 0, 1'b0, n);
      push_fill(n, 318, 238, 4, 4, 12'h123);
      drop();
      drain("clip_drain");
      chk("hold_x", int'(x), 319);
      chk("hold_y", int'(y), 239);

      // sums past 511 must not wrap back on screen
      p0 = plot_cnt;
      issue(1'b0, 510, 0, 4, 1, 12'hFFF, 0, 1'b0, n);
      push_fill(n, 510, 0, 4, 1, 12'hFFF);
      drop();
      drain("wrap_drain");
      chk("wrap_plot_count", plot_cnt - p0, 0);

      // sprite clipped on both edges, keyed (no key colour in id 3)
      issue(1'b1, 310, 230, 0, 0, 0, 3, 1'b1, n);
      push_sprite(n, 310, 230, 3, 1'b1);
      drop();
      drain("spr_clip_drain");

      // zero-size fill
      p0 = plot_cnt;
      issue(1'b0, 5, 5, 0, 5, 12'h111, 0, 1'b0, n);
      push_fill(n, 5, 5, 0, 5, 12'h111);
      drop();
      drain("zero_drain");
      chk("zero_plot_count", plot_cnt - p0, 0);

      // back-pressure: second command waits for the cycle after done
      issue(1'b0, 0, 0, 3, 1, 12'h123, 0, 1'b0, n);
      push_fill(n, 0, 0, 3, 1, 12'h123);
      issue(1'b0, 5, 5, 2, 2, 12'hABC, 0, 1'b0, n2);
      chk("bp_accept_cycle", n2, n + 5);
      push_fill(n2, 5, 5, 2, 2, 12'hABC);
      drop();
      drain("bp_drain");

      // reset in the middle of a sprite
      issue(1'b1, 40, 40, 0, 0, 0, 2, 1'b0, n);
      push_sprite(n, 40, 40, 2, 1'b0);
      drop();
      while (cyc < n + 49) @(negedge CLOCK_50);
      chk("pre_reset_plot", int'(plot), 1);
      chk("pre_reset_busy", int'(busy), 1);
      reset = 1'b1;
      #1;
      chk("mid_rst_plot", int'(plot), 0);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_done", int'(done), 0);
      chk("mid_rst_ready", int'(cmd_ready), 0);
      exp_q.delete();
      done_q.delete();
      repeat (2) @(negedge CLOCK_50);
      chk("held_rst_plot", int'(plot), 0);
      reset = 1'b0;
      @(negedge CLOCK_50);
      chk("ready_after_abort", int'(cmd_ready), 1);
      issue(1'b0, 7, 9, 2, 2, 12'h55A, 0, 1'b0, n);
      push_fill(n, 7, 9, 2, 2, 12'h55A);
      drop();
      drain("post_reset_drain");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
